// File: rtl/sram_dual_port_arbiter_pkg.sv
// Shared geometry, tag sizing and the SRAM command record for the
// dual-port SRAM arbiter.
package sram_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int NUM_PORTS   = 2;

    // A single requester still needs a one-bit tag.
    function automatic int tag_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int TAG_W = tag_width(NUM_REQ_DEF);

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
        logic [TAG_W-1:0]      tag;
    } sram_cmd_t;

    localparam sram_cmd_t CMD_IDLE = '0;

endpackage

// File: rtl/sram_dual_port_arbiter_if.sv
// Requester-side bus of the arbiter: flattened per-requester request
// fields, the combinational grant and the one-cycle completion pulse.
interface sram_dual_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        Req_Valid_In;
    logic [NUM_REQ-1:0]        Req_Write_In;
    logic [NUM_REQ*ADDR_W-1:0] Req_Addr_In;
    logic [NUM_REQ*DATA_W-1:0] Req_Data_In;
    logic [NUM_REQ-1:0]        Req_Ready_Out;
    logic [NUM_REQ-1:0]        Rsp_Valid_Out;
    logic [NUM_REQ*DATA_W-1:0] Rsp_Data_Out;

    modport master (
        output Req_Valid_In, Req_Write_In, Req_Addr_In, Req_Data_In,
        input  Req_Ready_Out, Rsp_Valid_Out, Rsp_Data_Out
    );

    modport slave (
        input  Req_Valid_In, Req_Write_In, Req_Addr_In, Req_Data_In,
        output Req_Ready_Out, Rsp_Valid_Out, Rsp_Data_Out
    );

endinterface

// File: rtl/sram_dual_port_arbiter_rr_find_first.sv
// Rotating priority encoder: first set bit of req at or after start,
// wrapping modulo N.
module rr_find_first #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W:0] pos;

    // Walk from the farthest offset back to start so the nearest hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
            if (req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
        if (found) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/sram_dual_port_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the two
// ports of a shared SRAM, with same-address hazard serialization.
module sram_dual_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                     Clk_In,
    input  logic                     Reset_In,
    sram_dual_port_arbiter_if.slave  req_bus,
    output logic [ADDR_W-1:0]        Port_A_Address_Out,
    output logic [DATA_W-1:0]        Port_A_Data_Out,
    output logic                     Port_A_Write_Enable,
    output logic                     Port_A_Read_Enable,
    input  logic [DATA_W-1:0]        Port_A_Data_In,
    output logic [ADDR_W-1:0]        Port_B_Address_Out,
    output logic [DATA_W-1:0]        Port_B_Data_Out,
    output logic                     Port_B_Write_Enable,
    output logic                     Port_B_Read_Enable,
    input  logic [DATA_W-1:0]        Port_B_Data_In
);

    localparam int IDX_W = tag_width(NUM_REQ);

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  tag;
    } cmd_t;

    logic [NUM_REQ-1:0]             req_vld;
    logic [NUM_REQ-1:0]             req_wr;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;

    assign req_vld  = req_bus.Req_Valid_In;
    assign req_wr   = req_bus.Req_Write_In;
    assign req_addr = req_bus.Req_Addr_In;
    assign req_data = req_bus.Req_Data_In;

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] oh_a, oh_b;
    logic [IDX_W-1:0]   idx_a, idx_b;
    logic               fnd_a, fnd_b;
    logic               hazard, gnt_a, gnt_b;

    rr_find_first #(.N(NUM_REQ), .IDX_W(IDX_W)) u_find_a (
        .req    (req_vld),
        .start  (ptr_q),
        .onehot (oh_a),
        .idx    (idx_a),
        .found  (fnd_a)
    );

    // Same rotation with the first winner masked yields the runner-up.
    rr_find_first #(.N(NUM_REQ), .IDX_W(IDX_W)) u_find_b (
        .req    (req_vld & ~oh_a),
        .start  (ptr_q),
        .onehot (oh_b),
        .idx    (idx_b),
        .found  (fnd_b)
    );

    assign hazard = fnd_b && (req_addr[idx_a] == req_addr[idx_b]) &&
                    (req_wr[idx_a] || req_wr[idx_b]);
    assign gnt_a  = Reset_In && fnd_a;
    assign gnt_b  = Reset_In && fnd_b && !hazard;

    assign req_bus.Req_Ready_Out = ({NUM_REQ{gnt_a}} & oh_a) | ({NUM_REQ{gnt_b}} & oh_b);

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Port B's winner is always later in the rotation than port A's.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_b)      ptr_d = wrap_inc(idx_b);
        else if (gnt_a) ptr_d = wrap_inc(idx_a);
    end

    cmd_t cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;

    function automatic cmd_t issue(input cmd_t prev, input logic gnt, input logic [IDX_W-1:0] idx,
                                   input logic wr, input logic [ADDR_W-1:0] addr,
                                   input logic [DATA_W-1:0] data);
        cmd_t c;
        c    = prev;
        c.rd = 1'b0;
        c.wr = 1'b0;
        if (gnt) begin
            c.rd   = !wr;
            c.wr   = wr;
            c.addr = addr;
            c.data = data;
            c.tag  = idx;
        end
        return c;
    endfunction

    always_comb begin
        cmd_a_d = issue(cmd_a_q, gnt_a, idx_a, req_wr[idx_a], req_addr[idx_a], req_data[idx_a]);
        cmd_b_d = issue(cmd_b_q, gnt_b, idx_b, req_wr[idx_b], req_addr[idx_b], req_data[idx_b]);
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            ptr_q   <= '0;
            cmd_a_q <= '0;
            cmd_b_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cmd_a_q <= cmd_a_d;
            cmd_b_q <= cmd_b_d;
        end
    end

    assign Port_A_Address_Out  = cmd_a_q.addr;
    assign Port_A_Data_Out     = cmd_a_q.data;
    assign Port_A_Write_Enable = cmd_a_q.wr;
    assign Port_A_Read_Enable  = cmd_a_q.rd;
    assign Port_B_Address_Out  = cmd_b_q.addr;
    assign Port_B_Data_Out     = cmd_b_q.data;
    assign Port_B_Write_Enable = cmd_b_q.wr;
    assign Port_B_Read_Enable  = cmd_b_q.rd;

    logic [NUM_REQ-1:0]             rsp_vld_d, rsp_vld_q;
    logic [NUM_REQ-1:0][DATA_W-1:0] rsp_data_d, rsp_data_q;

    // The two ports always carry distinct tags, so their completions never collide.
    always_comb begin
        rsp_vld_d  = '0;
        rsp_data_d = '0;
        if (cmd_a_q.rd || cmd_a_q.wr) begin
            rsp_vld_d[cmd_a_q.tag]  = 1'b1;
            rsp_data_d[cmd_a_q.tag] = cmd_a_q.rd ? Port_A_Data_In : '0;
        end
        if (cmd_b_q.rd || cmd_b_q.wr) begin
            rsp_vld_d[cmd_b_q.tag]  = 1'b1;
            rsp_data_d[cmd_b_q.tag] = cmd_b_q.rd ? Port_B_Data_In : '0;
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_vld_d[i]) rsp_data_q[i] <= rsp_data_d[i];
            end
        end
    end

    assign req_bus.Rsp_Valid_Out = rsp_vld_q;
    assign req_bus.Rsp_Data_Out  = rsp_data_q;

endmodule

// File: tb/tb_sram_dual_port_arbiter.sv
// Randomized and directed bench for sram_dual_port_arbiter against a
// transaction-level model of grants, SRAM contents and completions.
module tb_sram_dual_port_arbiter;
    import sram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int M_ONESHOT = 0;
    localparam int M_FAIR    = 1;
    localparam int M_RAND    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sram_dual_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] pa_addr, pb_addr;
    logic [DW-1:0] pa_wd, pb_wd, pa_rd, pb_rd;
    logic          pa_we, pa_re, pb_we, pb_re;

    sram_dual_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk_In              (clk),
        .Reset_In            (rst_n),
        .req_bus             (bus),
        .Port_A_Address_Out  (pa_addr),
        .Port_A_Data_Out     (pa_wd),
        .Port_A_Write_Enable (pa_we),
        .Port_A_Read_Enable  (pa_re),
        .Port_A_Data_In      (pa_rd),
        .Port_B_Address_Out  (pb_addr),
        .Port_B_Data_Out     (pb_wd),
        .Port_B_Write_Enable (pb_we),
        .Port_B_Read_Enable  (pb_re),
        .Port_B_Data_In      (pb_rd)
    );

    function automatic logic [DW-1:0] preload(input int a);
        case (a)
            'h10:    return 16'hBEEF;
            'h30:    return 16'hCAFE;
            default: return DW'(a * 37) ^ 16'h5A5A;
        endcase
    endfunction

    // SRAM: both ports sample on the falling edge; an idle read bus reads as 0.
    logic [DW-1:0] sram [256];
    initial begin
        for (int a = 0; a < 256; a++) sram[a] = preload(a);
        pa_rd = '0;
        pb_rd = '0;
        forever begin
            @(negedge clk);
            pa_rd = pa_re ? sram[pa_addr] : '0;
            pb_rd = pb_re ? sram[pb_addr] : '0;
            if (pa_we) sram[pa_addr] = pa_wd;
            if (pb_we) sram[pb_addr] = pb_wd;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Requester state and reference model.
    bit             rq_v [N];
    bit             rq_w [N];
    logic [AW-1:0]  rq_a [N];
    logic [DW-1:0]  rq_d [N];
    int             mode;

    int                   m_ptr;
    sram_cmd_t            exp_cmd [2];
    logic [DW-1:0]        s1_rdata [2];
    logic [N-1:0]         exp_vld;
    logic [N-1:0][DW-1:0] exp_data;
    logic [DW-1:0]        exp_mem [256];

    logic [N-1:0]         obs_rdy, obs_vld;
    logic [N-1:0][DW-1:0] obs_data;
    logic [3:0]           obs_en;

    task automatic reset_model();
        m_ptr      = 0;
        exp_cmd[0] = CMD_IDLE;
        exp_cmd[1] = CMD_IDLE;
        s1_rdata[0] = '0;
        s1_rdata[1] = '0;
        exp_vld    = '0;
        exp_data   = '0;
    endtask

    task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq_v[i] = 1'b1;
        rq_w[i] = w;
        rq_a[i] = a;
        rq_d[i] = d;
    endtask

    task automatic clear_req();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
        for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.Req_Valid_In[i]             = rq_v[i];
            bus.Req_Write_In[i]             = rq_w[i];
            bus.Req_Addr_In[i*AW +: AW]     = rq_a[i];
            bus.Req_Data_In[i*DW +: DW]     = rq_d[i];
        end
    endtask

    task automatic issue(input int p, input int r);
        exp_cmd[p].rd = 1'b0;
        exp_cmd[p].wr = 1'b0;
        if (r >= 0) begin
            exp_cmd[p].rd   = !rq_w[r];
            exp_cmd[p].wr   = rq_w[r];
            exp_cmd[p].addr = rq_a[r];
            exp_cmd[p].data = rq_d[r];
            exp_cmd[p].tag  = TAG_W'(r);
            s1_rdata[p]     = exp_mem[rq_a[r]];
            if (rq_w[r]) exp_mem[rq_a[r]] = rq_d[r];
        end
    endtask

    task automatic rearm(input int ga, input int gb);
        if (mode == M_FAIR) return;
        if (ga >= 0) rq_v[ga] = 1'b0;
        if (gb >= 0) rq_v[gb] = 1'b0;
        if (mode == M_RAND) begin
            for (int i = 0; i < N; i++) begin
                if (!rq_v[i] && $urandom_range(0, 3) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            end
        end
    endtask

    // One cycle: entered at posedge+1, checks at posedge+4, leaves at next posedge+1.
    task automatic step();
        int           cand[$];
        int           ga, gb, r;
        logic [N-1:0] g;
        drive();
        #3;
        ga = -1;
        gb = -1;
        for (int k = 0; k < N; k++) begin
            r = (m_ptr + k) % N;
            if (rq_v[r]) cand.push_back(r);
        end
        if (rst_n && cand.size() > 0) ga = cand[0];
        if (rst_n && cand.size() > 1 &&
            !(rq_a[cand[0]] == rq_a[cand[1]] && (rq_w[cand[0]] || rq_w[cand[1]])))
            gb = cand[1];
        g = '0;
        if (ga >= 0) g[ga] = 1'b1;
        if (gb >= 0) g[gb] = 1'b1;

        obs_rdy  = bus.Req_Ready_Out;
        obs_vld  = bus.Rsp_Valid_Out;
        obs_data = bus.Rsp_Data_Out;
        obs_en   = {pa_re, pa_we, pb_re, pb_we};
        chk("ready", 64'(obs_rdy), 64'(g));
        chk("rsp_valid", 64'(obs_vld), 64'(exp_vld));
        chk("rsp_data", 64'(obs_data), 64'(exp_data));
        chk("port_a", 64'({pa_re, pa_we, pa_addr, pa_wd}),
            64'({exp_cmd[0].rd, exp_cmd[0].wr, exp_cmd[0].addr, exp_cmd[0].data}));
        chk("port_b", 64'({pb_re, pb_we, pb_addr, pb_wd}),
            64'({exp_cmd[1].rd, exp_cmd[1].wr, exp_cmd[1].addr, exp_cmd[1].data}));

        exp_vld = '0;
        for (int p = 0; p < 2; p++) begin
            if (exp_cmd[p].rd || exp_cmd[p].wr) begin
                exp_vld[exp_cmd[p].tag]  = 1'b1;
                exp_data[exp_cmd[p].tag] = exp_cmd[p].rd ? s1_rdata[p] : '0;
            end
        end
        issue(0, ga);
        issue(1, gb);
        if (gb >= 0)      m_ptr = (gb + 1) % N;
        else if (ga >= 0) m_ptr = (ga + 1) % N;

        @(posedge clk);
        #1;
        rearm(ga, gb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int cnt [N];

    initial begin
        mode = M_ONESHOT;
        for (int a = 0; a < 256; a++) exp_mem[a] = preload(a);
        reset_model();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
        drive();
        #1 rst_n = 1'b0;

        // Reset state, with every requester asking.
        @(posedge clk);
        #4;
        chk("rst_ready", 64'(bus.Req_Ready_Out), 64'(0));
        chk("rst_enables", 64'({pa_re, pa_we, pb_re, pb_we}), 64'(0));
        chk("rst_rsp_valid", 64'(bus.Rsp_Valid_Out), 64'(0));
        chk("rst_rsp_data", 64'(bus.Rsp_Data_Out), 64'(0));
        chk("rst_port_addr", 64'({pa_addr, pb_addr, pa_wd, pb_wd}), 64'(0));
        clear_req();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Single read of a preloaded word.
        set_req(2, 1'b0, 8'h10, 16'h0);
        step();
        chk("single_ready", 64'(obs_rdy), 64'(4'b0100));
        step();
        step();
        chk("single_valid", 64'(obs_vld), 64'(4'b0100));
        chk("single_data", 64'(obs_data[2]), 64'(16'hBEEF));
        step();
        chk("single_one_pulse", 64'(obs_vld), 64'(0));

        // Write on A and read on B in the same cycle.
        set_req(0, 1'b1, 8'h20, 16'h1234);
        set_req(1, 1'b0, 8'h30, 16'h0);
        step();
        chk("dual_ready", 64'(obs_rdy), 64'(4'b0011));
        step();
        chk("dual_enables", 64'(obs_en), 64'(4'b0110));
        step();
        chk("dual_valid", 64'(obs_vld), 64'(4'b0011));
        chk("dual_data", 64'(obs_data[1]), 64'(16'hCAFE));

        // Bring the pointer back to 0, then a write/read clash on one address.
        set_req(3, 1'b0, 8'h01, 16'h0);
        repeat (3) step();
        set_req(0, 1'b1, 8'h40, 16'h5555);
        set_req(1, 1'b0, 8'h40, 16'h0);
        step();
        chk("hazard_first", 64'(obs_rdy), 64'(4'b0001));
        step();
        chk("hazard_second", 64'(obs_rdy), 64'(4'b0010));
        step();
        step();
        chk("hazard_data", 64'(obs_data[1]), 64'(16'h5555));

        // Continuous requests from everyone.
        set_req(3, 1'b0, 8'h01, 16'h0);
        repeat (3) step();
        mode = M_FAIR;
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, AW'(8'h50 + i), 16'h0);
            cnt[i] = 0;
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 8) clear_req();
            step();
            if (c == 0) chk("fair_pair0", 64'(obs_rdy), 64'(4'b0011));
            if (c == 1) chk("fair_pair1", 64'(obs_rdy), 64'(4'b1100));
            for (int i = 0; i < N; i++) if (obs_vld[i]) cnt[i]++;
        end
        mode = M_ONESHOT;
        for (int i = 0; i < N; i++) chk($sformatf("fair_count%0d", i), 64'(cnt[i]), 64'(4));

        // Reset lands between issue and completion of a read.
        set_req(2, 1'b0, 8'h10, 16'h0);
        step();
        chk("midrst_accept", 64'(obs_rdy), 64'(4'b0100));
        rst_n = 1'b0;
        #1;
        chk("midrst_enables", 64'({pa_re, pa_we, pb_re, pb_we}), 64'(0));
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(8'h60 + i), 16'h0);
        drive();
        #1;
        chk("midrst_ready", 64'(bus.Req_Ready_Out), 64'(0));
        repeat (2) begin
            @(posedge clk);
            #4;
            chk("midrst_no_rsp", 64'(bus.Rsp_Valid_Out), 64'(0));
        end
        reset_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("midrst_restart", 64'(obs_rdy), 64'(4'b0011));
        clear_req();
        repeat (3) step();

        // Random traffic over a small address window to provoke clashes.
        mode = M_RAND;
        repeat (400) step();
        mode = M_ONESHOT;
        clear_req();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_dual_port_arbiter.md
Name: sram_dual_port_arbiter

Overview:
- Shares one 16-bit dual-port SRAM (256 x 16, two independent ports, both sampling on the falling clock edge) between NUM_REQ requesters.
- Each cycle it arbitrates round-robin and grants up to two requests, one per SRAM port.
- It serializes same-address hazards and returns read data to the requester with a fixed one-cycle latency.
- It sits between the bus-side masters and the SRAM; it is the only driver of the SRAM port controls.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, SRAM address width.
- DATA_W, 16, SRAM data width.

Ports:
- Clk_In  in  1  system clock; all controller flops use the rising edge.
- Reset_In  in  1  asynchronous, active-low reset.
- Req_Valid_In  in  NUM_REQ  request valid, one bit per requester.
- Req_Write_In  in  NUM_REQ  1 = write, 0 = read.
- Req_Addr_In  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- Req_Data_In  in  NUM_REQ*DATA_W  flattened write data.
- Req_Ready_Out  out  NUM_REQ  grant; combinational in the same cycle.
- Rsp_Valid_Out  out  NUM_REQ  one-cycle completion pulse, for both reads and writes.
- Rsp_Data_Out  out  NUM_REQ*DATA_W  read data; zero for write completions.
- Port_A_Address_Out  out  ADDR_W  SRAM port A address (registered).
- Port_A_Data_Out  out  DATA_W  SRAM port A write data (registered).
- Port_A_Write_Enable  out  1  SRAM port A write enable (registered).
- Port_A_Read_Enable  out  1  SRAM port A read enable (registered).
- Port_A_Data_In  in  DATA_W  SRAM port A read data; Z when the port is not reading.
- Port_B_Address_Out, Port_B_Data_Out, Port_B_Write_Enable, Port_B_Read_Enable, Port_B_Data_In: same as port A, for port B.

Behaviour:
- Reset (Reset_In = 0, asynchronous):
  - All enables, Rsp_Valid_Out, Rsp_Data_Out, addresses and write data go to 0.
  - Round-robin pointer goes to 0. Any in-flight response is discarded.
  - Req_Ready_Out is forced to 0 while reset is asserted.
- Arbitration (combinational, every cycle):
  - Scan Req_Valid_In starting at the pointer and wrapping modulo NUM_REQ.
  - First valid requester -> port A. Second valid requester -> port B.
  - Hazard: if both candidates use the same address and at least one is a write, grant only the first; port B idles that cycle.
  - Two reads of the same address are both granted.
- Handshake:
  - A request is accepted on a rising edge where Req_Valid_In[i] and Req_Ready_Out[i] are both 1.
  - The requester must hold valid, write, address and data stable until accepted.
  - Ready may assert in the same cycle valid rises.
- Issue:
  - At the accept edge E0, the port's command registers load. Exactly one of Read_Enable or Write_Enable is set (never both), along with address, data and the requester-index tag.
  - An ungranted port gets both enables 0; its address and data hold their previous values.
  - The SRAM samples the command at the falling edge inside the E0 cycle.
- Completion:
  - At rising edge E1 = E0 + 1, the controller captures Port_x_Data_In, but only if that port issued a read.
  - It pulses Rsp_Valid_Out[tag] for one cycle, with Rsp_Data_Out[tag] = captured data.
  - Read latency is 1 cycle from acceptance. A write completes at E1 with data 0.
  - Rsp_Data_Out[i] holds its last value when Rsp_Valid_Out[i] = 0.
- Pointer:
  - After any grant, pointer <= (index of last granted requester + 1) mod NUM_REQ.
  - With no grant, the pointer is unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles, including under hazard serialization.
- Throughput: 2 accesses per cycle peak, with no bubbles between back-to-back grants.
- Same-requester back-to-back: a requester may be granted on consecutive cycles. Its responses then arrive on consecutive cycles in order; ordering per requester is preserved.
- Reset mid-operation: a command issued at E0 with reset falling before E1 produces no response. The SRAM write itself may or may not have landed.

Decomposition:
- Shared package sram_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - TAG_W = clog2(NUM_REQ).
  - Typedef sram_cmd_t {rd, wr, addr, data, tag}.
  - Constant CMD_IDLE.
- Sub-module rr_find_first (rotating priority encoder: request vector + start pointer -> one-hot + index + found flag). Instantiated twice; the second instance uses a mask that excludes the first winner.

Test Plan:
- Single read: SRAM preloaded with mem[0x10] = 0xBEEF; requester 2 reads 0x10 -> Ready_Out[2] = 1 the same cycle; Rsp_Valid_Out[2] pulses exactly one cycle later with data 0xBEEF.
- Dual grant: req0 writes 0x20 = 0x1234 and req1 reads 0x30 = 0xCAFE in the same cycle -> both ready; port A write, port B read in one cycle; Rsp_Valid_Out[0] and Rsp_Valid_Out[1] pulse together, Rsp_Data_Out[1] = 0xCAFE.
- Hazard: req0 writes 0x40 = 0x5555 and req1 reads 0x40, pointer = 0 -> only req0 granted; next cycle req1 is granted and reads 0x5555.
- Fairness: all 4 requesters valid continuously for 8 cycles -> grant pairs (0,1),(2,3),(0,1)...; each requester receives 4 responses.
- Reset: assert Reset_In = 0 one cycle after a read is accepted -> no Rsp_Valid_Out pulse; all enables 0 immediately; after release, the first grant starts from requester 0.
